// File: rtl/core_copy_pkg.sv
// Shared types and constants for the core-to-core RAM copy master.
package core_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BE_W       = 4;
  localparam logic [BE_W-1:0] BE_ALL = 4'hF;

endpackage

// File: rtl/core_ram_copy_master_if.sv
// Avalon-MM initiator bus between the copy master and the interconnect.
interface core_ram_copy_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_write;
  logic [3:0]        m_byteenable;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic              m_waitrequest;
  logic              m_readdatavalid;

  modport master (
    output m_address, m_read, m_write, m_byteenable, m_writedata,
    input  m_readdata, m_waitrequest, m_readdatavalid
  );

  modport slave (
    input  m_address, m_read, m_write, m_byteenable, m_writedata,
    output m_readdata, m_waitrequest, m_readdatavalid
  );

endinterface

// File: rtl/core_ram_copy_master.sv
// Copies len_words 32-bit words from src_addr to dst_addr, one word in flight.
// Optional running sum of written words enabled by `define CORE_COPY_CHECKSUM_EN.
module core_ram_copy_master
  import core_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done,
`ifdef CORE_COPY_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  core_ram_copy_master_if.master m
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("core_ram_copy_master: DATA_W must be 32");
  end

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(WORD_BYTES - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_words_done;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_address;
  logic              r_read;
  logic              r_write;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
`ifdef CORE_COPY_CHECKSUM_EN
  logic [31:0]       r_checksum;
`endif

  logic [ADDR_W-1:0] w_src_next;
  logic [ADDR_W-1:0] w_dst_next;
  logic              w_last_word;

  assign w_src_next  = r_src + ADDR_STEP;
  assign w_dst_next  = r_dst + ADDR_STEP;
  assign w_last_word = (r_words_done + LEN_W'(1)) == r_len;

  // Single-process FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_words_done <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_address    <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_be         <= '0;
      r_wdata      <= '0;
`ifdef CORE_COPY_CHECKSUM_EN
      r_checksum   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_words_done <= '0;
            r_busy       <= 1'b1;
`ifdef CORE_COPY_CHECKSUM_EN
            r_checksum   <= '0;
`endif
            if (len_words == '0) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_src     <= src_addr & ADDR_MASK;
              r_dst     <= dst_addr & ADDR_MASK;
              r_len     <= len_words;
              r_address <= src_addr & ADDR_MASK;
              r_read    <= 1'b1;
              r_be      <= BE_ALL;
              r_state   <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (!m.m_waitrequest) begin
            r_read  <= 1'b0;
            r_be    <= '0;
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (m.m_readdatavalid) begin
            r_wdata   <= m.m_readdata;
            r_address <= r_dst;
            r_write   <= 1'b1;
            r_be      <= BE_ALL;
            r_state   <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (!m.m_waitrequest) begin
            r_write      <= 1'b0;
            r_be         <= '0;
            r_src        <= w_src_next;
            r_dst        <= w_dst_next;
            r_words_done <= r_words_done + LEN_W'(1);
`ifdef CORE_COPY_CHECKSUM_EN
            r_checksum   <= r_checksum + 32'(r_wdata);
`endif
            if (w_last_word) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_address <= w_src_next;
              r_read    <= 1'b1;
              r_be      <= BE_ALL;
              r_state   <= RD_REQ;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign words_done     = r_words_done;
  assign m.m_address    = r_address;
  assign m.m_read       = r_read;
  assign m.m_write      = r_write;
  assign m.m_byteenable = r_be;
  assign m.m_writedata  = r_wdata;
`ifdef CORE_COPY_CHECKSUM_EN
  assign checksum       = r_checksum;
`endif

endmodule

// File: doc/core_ram_copy_master.md
Name: core_ram_copy_master

Overview:
- Avalon-MM initiator that copies a block of 32-bit words from one core-local on-chip RAM to another, e.g. core_0 RAM into core_7 RAM.
- Sits on the multicore interconnect beside the per-core RAM slaves.
- Driven by a simple start/busy/done control port from a supervising core or a test sequencer.
- Strictly one word in flight: read one word, then write it, then repeat.

Parameters:
- ADDR_W, 32, byte-address width of the master port.
- DATA_W, 32, data width; fixed at 32 and checked at elaboration.
- LEN_W, 11, width of the word-count input; max 1024 words, the per-core RAM depth.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- src_addr  in  ADDR_W  source byte address; bits [1:0] ignored (treated as 0)
- dst_addr  in  ADDR_W  destination byte address; bits [1:0] ignored
- len_words  in  LEN_W  number of words to copy
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  one-cycle completion pulse
- words_done  out  LEN_W  count of words written so far
- m_address  out  ADDR_W  Avalon byte address, word-aligned
- m_read  out  1  Avalon read
- m_write  out  1  Avalon write
- m_byteenable  out  4  4'hF while a command is asserted, else 4'h0
- m_writedata  out  32  Avalon write data
- m_readdata  in  32  Avalon read data
- m_waitrequest  in  1  slave stall
- m_readdatavalid  in  1  read data valid

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high; all state updates on the rising edge of clk.
- Values after reset: state=IDLE; m_read, m_write, busy, done = 0; m_address, m_writedata, words_done = 0; m_byteenable = 0.
- States:
  - IDLE: on start with len_words>0, latch src, dst and len; clear words_done; go to RD_REQ.
  - IDLE, len_words==0: on start go straight to DONE with no bus activity.
  - RD_REQ: m_read=1, m_address=cur_src. Hold address and command stable while m_waitrequest=1. On acceptance (m_waitrequest=0) go to RD_WAIT.
  - RD_WAIT: commands deasserted. On m_readdatavalid, capture m_readdata and go to WR_REQ.
  - WR_REQ: m_write=1, m_address=cur_dst, m_writedata=captured word. Hold stable under waitrequest.
  - On write acceptance: cur_src+=4, cur_dst+=4, words_done+=1. If words_done+1==len, go to DONE; else go to RD_REQ.
  - DONE: done=1 for exactly one cycle, then IDLE. busy drops to 0 together with that transition.
- Latency: zero wait states and readdatavalid one cycle after read acceptance give 3 cycles per word.
  - start at cycle 0 -> m_read at cycle 1 -> done at cycle 3N+1.
  - len_words=0 -> done at cycle 1.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is permitted and not flagged.
- start while not in IDLE is ignored. Inputs are sampled only on the accepting cycle, so later changes have no effect.
- m_readdatavalid outside RD_WAIT is ignored: no capture, no state change.
- Never asserts m_read and m_write in the same cycle.
- reset mid-transfer: next cycle all outputs return to their reset values. The transfer is abandoned with no done pulse. A partially written destination is left as-is.
- Simultaneous start and reset: reset wins.

Optional Feature:
- Macro: CORE_COPY_CHECKSUM_EN.
- When defined:
  - Adds output checksum[31:0]: the 32-bit modulo-2^32 sum of every word written.
  - Cleared on accepted start and on reset.
  - Updated in the cycle the write is accepted.
  - Valid and stable from the done pulse until the next start.
- When undefined: the port and the accumulator are absent; all other behaviour is identical.

Decomposition:
- Package core_copy_pkg:
  - state enum {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE}
  - WORD_BYTES=4
  - BE_ALL=4'hF
- No sub-module. The FSM and datapath are small and belong in one module; the checksum stays inline behind the macro.

Test Plan:
- src=0x0000, dst=0x1000, len=4, no waits, readdatavalid 1 cycle late, source words 0x11111111..0x44444444 -> dst holds same 4 words; done at cycle 13; words_done=4; busy high cycles 1..13.
- len=0 start -> done at cycle 1; m_read and m_write never asserted.
- len=2, m_waitrequest high 3 cycles on each command -> address, command and writedata held stable while stalled; data copied correctly; done at cycle 2*(3+6)+1=19.
- Spurious m_readdatavalid in WR_REQ, plus start pulses while busy -> ignored; copy result and words_done unaffected.
- reset asserted in RD_WAIT of word 3 of 8 -> next cycle all outputs 0; no done pulse; new start with len=1 completes normally.
- CORE_COPY_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001 at done.
